// File: rtl/layer_pingpong_scheduler.sv
// rtl/layer_pingpong_scheduler.sv - ping-pong bank scheduler between a producer and a consumer CNN layer
// Optional watchdog on each RUN state is compiled in with PINGPONG_WDOG_EN.
module layer_pingpong_scheduler #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,

  output logic                  o_prod_enable,
  output logic                  o_prod_reset,
  input  logic                  i_prod_done,
  input  logic [ADDR_WIDTH-1:0] i_prod_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_prod_addr_b,
  input  logic                  i_prod_rden_a,
  input  logic                  i_prod_rden_b,
  input  logic                  i_prod_wren_a,
  input  logic                  i_prod_wren_b,

  output logic                  o_cons_enable,
  output logic                  o_cons_reset,
  input  logic                  i_cons_done,
  input  logic [ADDR_WIDTH-1:0] i_cons_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_cons_addr_b,
  input  logic                  i_cons_rden_a,
  input  logic                  i_cons_rden_b,
  input  logic                  i_cons_wren_a,
  input  logic                  i_cons_wren_b,

  output logic [ADDR_WIDTH-1:0] o_b0_addr_a,
  output logic [ADDR_WIDTH-1:0] o_b0_addr_b,
  output logic                  o_b0_rden_a,
  output logic                  o_b0_rden_b,
  output logic                  o_b0_wren_a,
  output logic                  o_b0_wren_b,

  output logic [ADDR_WIDTH-1:0] o_b1_addr_a,
  output logic [ADDR_WIDTH-1:0] o_b1_addr_b,
  output logic                  o_b1_rden_a,
  output logic                  o_b1_rden_b,
  output logic                  o_b1_wren_a,
  output logic                  o_b1_wren_b,

  output logic                  o_cons_q_sel,
  output logic [7:0]            o_frames_done,
  output logic                  o_wdog_err
);

  localparam int BUS_W = 2 * ADDR_WIDTH + 4;

  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_DRAIN} bank_t;
  typedef enum logic [1:0] {P_IDLE, P_RST, P_RUN} p_state_t;
  typedef enum logic [1:0] {C_IDLE, C_RST, C_RUN} c_state_t;

  p_state_t r_p_state, w_p_next;
  c_state_t r_c_state, w_c_next;
  bank_t    r_bank0, r_bank1, w_bank0_next, w_bank1_next;
  bank_t    w_bank_wr, w_bank_rd;
  logic     r_wr_bank, r_rd_bank;
  logic [7:0] r_frames;

  logic w_p_start, w_p_done, w_p_to, w_p_wdog_hit;
  logic w_c_start, w_c_done, w_c_to, w_c_wdog_hit;

  logic [BUS_W-1:0] w_prod_bus, w_cons_bus, w_b0_bus, w_b1_bus;

  assign w_bank_wr = r_wr_bank ? r_bank1 : r_bank0;
  assign w_bank_rd = r_rd_bank ? r_bank1 : r_bank0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_state <= P_IDLE;
      r_c_state <= C_IDLE;
    end else begin
      r_p_state <= w_p_next;
      r_c_state <= w_c_next;
    end
  end

  always_comb begin
    w_p_next  = r_p_state;
    w_p_start = 1'b0;
    w_p_done  = 1'b0;
    w_p_to    = 1'b0;
    case (r_p_state)
      P_IDLE: begin
        if (i_enable && (w_bank_wr == B_FREE)) begin
          w_p_start = 1'b1;
          w_p_next  = P_RST;
        end
      end
      P_RST: w_p_next = P_RUN;
      P_RUN: begin
        if (i_prod_done) begin
          w_p_done = 1'b1;
          w_p_next = P_IDLE;
        end else if (w_p_wdog_hit) begin
          w_p_to   = 1'b1;
          w_p_next = P_IDLE;
        end
      end
      default: w_p_next = P_IDLE;
    endcase
  end

  always_comb begin
    w_c_next  = r_c_state;
    w_c_start = 1'b0;
    w_c_done  = 1'b0;
    w_c_to    = 1'b0;
    case (r_c_state)
      C_IDLE: begin
        if (i_enable && (w_bank_rd == B_FULL)) begin
          w_c_start = 1'b1;
          w_c_next  = C_RST;
        end
      end
      C_RST: w_c_next = C_RUN;
      C_RUN: begin
        if (i_cons_done) begin
          w_c_done = 1'b1;
          w_c_next = C_IDLE;
        end else if (w_c_wdog_hit) begin
          w_c_to   = 1'b1;
          w_c_next = C_IDLE;
        end
      end
      default: w_c_next = C_IDLE;
    endcase
  end

  // Producer and consumer events always target banks in different states, so they never collide.
  always_comb begin
    w_bank0_next = r_bank0;
    w_bank1_next = r_bank1;
    if (w_p_start) begin
      if (r_wr_bank) w_bank1_next = B_FILL; else w_bank0_next = B_FILL;
    end
    if (w_p_done) begin
      if (r_wr_bank) w_bank1_next = B_FULL; else w_bank0_next = B_FULL;
    end
    if (w_p_to) begin
      if (r_wr_bank) w_bank1_next = B_FREE; else w_bank0_next = B_FREE;
    end
    if (w_c_start) begin
      if (r_rd_bank) w_bank1_next = B_DRAIN; else w_bank0_next = B_DRAIN;
    end
    if (w_c_done || w_c_to) begin
      if (r_rd_bank) w_bank1_next = B_FREE; else w_bank0_next = B_FREE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank0   <= B_FREE;
      r_bank1   <= B_FREE;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_frames  <= 8'd0;
    end else begin
      r_bank0   <= w_bank0_next;
      r_bank1   <= w_bank1_next;
      r_wr_bank <= r_wr_bank ^ (w_p_done | w_p_to);
      r_rd_bank <= r_rd_bank ^ (w_c_done | w_c_to);
      if (w_c_done) r_frames <= r_frames + 8'd1;
    end
  end

`ifdef PINGPONG_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] r_p_cnt, r_c_cnt;
  logic        r_wdog_err;

  // Counters run only while in RUN, so they are zero on every RUN entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_cnt    <= 16'd0;
      r_c_cnt    <= 16'd0;
      r_wdog_err <= 1'b0;
    end else begin
      r_p_cnt    <= (r_p_state == P_RUN) ? r_p_cnt + 16'd1 : 16'd0;
      r_c_cnt    <= (r_c_state == C_RUN) ? r_c_cnt + 16'd1 : 16'd0;
      r_wdog_err <= r_wdog_err | w_p_to | w_c_to;
    end
  end

  assign w_p_wdog_hit = (r_p_cnt == WDOG_LAST);
  assign w_c_wdog_hit = (r_c_cnt == WDOG_LAST);
  assign o_wdog_err   = r_wdog_err;
`else
  logic w_unused_wdog;

  assign w_unused_wdog = (WDOG_CYCLES != 0);
  assign w_p_wdog_hit  = 1'b0;
  assign w_c_wdog_hit  = 1'b0;
  assign o_wdog_err    = 1'b0;
`endif

  assign w_prod_bus = {i_prod_addr_a, i_prod_addr_b, i_prod_rden_a, i_prod_rden_b,
                       i_prod_wren_a, i_prod_wren_b};
  assign w_cons_bus = {i_cons_addr_a, i_cons_addr_b, i_cons_rden_a, i_cons_rden_b,
                       i_cons_wren_a, i_cons_wren_b};

  always_comb begin
    w_b0_bus = '0;
    w_b1_bus = '0;
    case (r_bank0)
      B_FILL:  w_b0_bus = w_prod_bus;
      B_DRAIN: w_b0_bus = w_cons_bus;
      default: w_b0_bus = '0;
    endcase
    case (r_bank1)
      B_FILL:  w_b1_bus = w_prod_bus;
      B_DRAIN: w_b1_bus = w_cons_bus;
      default: w_b1_bus = '0;
    endcase
  end

  assign {o_b0_addr_a, o_b0_addr_b, o_b0_rden_a, o_b0_rden_b, o_b0_wren_a, o_b0_wren_b} = w_b0_bus;
  assign {o_b1_addr_a, o_b1_addr_b, o_b1_rden_a, o_b1_rden_b, o_b1_wren_a, o_b1_wren_b} = w_b1_bus;

  assign o_prod_reset  = (r_p_state == P_RST);
  assign o_prod_enable = (r_p_state == P_RUN);
  assign o_cons_reset  = (r_c_state == C_RST);
  assign o_cons_enable = (r_c_state == C_RUN);
  assign o_cons_q_sel  = r_rd_bank;
  assign o_frames_done = r_frames;

endmodule

// File: tb/tb_layer_pingpong_scheduler.sv
// tb/tb_layer_pingpong_scheduler.sv - self-checking bench for layer_pingpong_scheduler
module tb_layer_pingpong_scheduler;

  localparam int AW   = 9;
  localparam int WDOG = 50;
`ifdef PINGPONG_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, prod_done = 1'b0, cons_done = 1'b0;
  logic [AW-1:0] p_addr_a = '0, p_addr_b = '0, c_addr_a = '0, c_addr_b = '0;
  logic p_rden_a = 1'b0, p_rden_b = 1'b0, p_wren_a = 1'b0, p_wren_b = 1'b0;
  logic c_rden_a = 1'b0, c_rden_b = 1'b0, c_wren_a = 1'b0, c_wren_b = 1'b0;

  logic o_prod_enable, o_prod_reset, o_cons_enable, o_cons_reset;
  logic [AW-1:0] o_b0_addr_a, o_b0_addr_b, o_b1_addr_a, o_b1_addr_b;
  logic o_b0_rden_a, o_b0_rden_b, o_b0_wren_a, o_b0_wren_b;
  logic o_b1_rden_a, o_b1_rden_b, o_b1_wren_a, o_b1_wren_b;
  logic o_cons_q_sel, o_wdog_err;
  logic [7:0] o_frames_done;

  layer_pingpong_scheduler #(.ADDR_WIDTH(AW), .WDOG_CYCLES(WDOG)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .o_prod_enable(o_prod_enable), .o_prod_reset(o_prod_reset), .i_prod_done(prod_done),
    .i_prod_addr_a(p_addr_a), .i_prod_addr_b(p_addr_b),
    .i_prod_rden_a(p_rden_a), .i_prod_rden_b(p_rden_b),
    .i_prod_wren_a(p_wren_a), .i_prod_wren_b(p_wren_b),
    .o_cons_enable(o_cons_enable), .o_cons_reset(o_cons_reset), .i_cons_done(cons_done),
    .i_cons_addr_a(c_addr_a), .i_cons_addr_b(c_addr_b),
    .i_cons_rden_a(c_rden_a), .i_cons_rden_b(c_rden_b),
    .i_cons_wren_a(c_wren_a), .i_cons_wren_b(c_wren_b),
    .o_b0_addr_a(o_b0_addr_a), .o_b0_addr_b(o_b0_addr_b),
    .o_b0_rden_a(o_b0_rden_a), .o_b0_rden_b(o_b0_rden_b),
    .o_b0_wren_a(o_b0_wren_a), .o_b0_wren_b(o_b0_wren_b),
    .o_b1_addr_a(o_b1_addr_a), .o_b1_addr_b(o_b1_addr_b),
    .o_b1_rden_a(o_b1_rden_a), .o_b1_rden_b(o_b1_rden_b),
    .o_b1_wren_a(o_b1_wren_a), .o_b1_wren_b(o_b1_wren_b),
    .o_cons_q_sel(o_cons_q_sel), .o_frames_done(o_frames_done), .o_wdog_err(o_wdog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int cyc      = 0;
  int p_len    = 0;
  int c_len    = 0;

  // Reference model: bank owners (0 free, 1 fill, 2 full, 3 drain), pointers, and
  // the age of each layer run (-1 idle, 0 restart cycle, n = n-th enabled cycle).
  int m_bank[2];
  int m_wr, m_rd, m_frames, m_werr, m_p_age, m_c_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic model_reset();
    m_bank[0] = 0; m_bank[1] = 0;
    m_wr = 0; m_rd = 0; m_frames = 0; m_werr = 0;
    m_p_age = -1; m_c_age = -1;
  endtask

  task automatic model_step(input bit en, input bit pd, input bit cd);
    int  wr, rd;
    bit  ps, pdn, pto, cs, cdn, cto;
    wr  = m_wr;
    rd  = m_rd;
    ps  = (m_p_age < 0) && en && (m_bank[wr] == 0);
    pdn = (m_p_age >= 1) && pd;
    pto = WD_ON && (m_p_age == WDOG) && !pd;
    cs  = (m_c_age < 0) && en && (m_bank[rd] == 2);
    cdn = (m_c_age >= 1) && cd;
    cto = WD_ON && (m_c_age == WDOG) && !cd;
    if (ps) m_p_age = 0; else if (pdn || pto) m_p_age = -1; else if (m_p_age >= 0) m_p_age++;
    if (cs) m_c_age = 0; else if (cdn || cto) m_c_age = -1; else if (m_c_age >= 0) m_c_age++;
    if (ps)  m_bank[wr] = 1;
    if (pdn) begin m_bank[wr] = 2; m_wr = 1 - wr; end
    if (pto) begin m_bank[wr] = 0; m_wr = 1 - wr; m_werr = 1; end
    if (cs)  m_bank[rd] = 3;
    if (cdn) begin m_bank[rd] = 0; m_rd = 1 - rd; m_frames = (m_frames + 1) % 256; end
    if (cto) begin m_bank[rd] = 0; m_rd = 1 - rd; m_werr = 1; end
  endtask

  function automatic logic [2*AW+3:0] exp_bank(input int st);
    if (st == 1) return {p_addr_a, p_addr_b, p_rden_a, p_rden_b, p_wren_a, p_wren_b};
    if (st == 3) return {c_addr_a, c_addr_b, c_rden_a, c_rden_b, c_wren_a, c_wren_b};
    return '0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("prod_reset",  32'(o_prod_reset),  32'(m_p_age == 0));
      chk("prod_enable", 32'(o_prod_enable), 32'(m_p_age >= 1));
      chk("cons_reset",  32'(o_cons_reset),  32'(m_c_age == 0));
      chk("cons_enable", 32'(o_cons_enable), 32'(m_c_age >= 1));
      chk("cons_q_sel",  32'(o_cons_q_sel),  32'(m_rd));
      chk("frames_done", 32'(o_frames_done), 32'(m_frames));
      chk("wdog_err",    32'(o_wdog_err),    32'(m_werr));
      chk("bank0_ports", 32'({o_b0_addr_a, o_b0_addr_b, o_b0_rden_a, o_b0_rden_b, o_b0_wren_a, o_b0_wren_b}),
          32'(exp_bank(m_bank[0])));
      chk("bank1_ports", 32'({o_b1_addr_a, o_b1_addr_b, o_b1_rden_a, o_b1_rden_b, o_b1_wren_a, o_b1_wren_b}),
          32'(exp_bank(m_bank[1])));
    end
  end

  task automatic set_inputs(input logic v);
    enable = v; prod_done = v; cons_done = v;
    p_addr_a = {AW{v}}; p_addr_b = {AW{v}}; c_addr_a = {AW{v}}; c_addr_b = {AW{v}};
    p_rden_a = v; p_rden_b = v; p_wren_a = v; p_wren_b = v;
    c_rden_a = v; c_rden_b = v; c_wren_a = v; c_wren_b = v;
  endtask

  task automatic start_scn(input int pl, input int cl);
    rst_n = 1'b0;
    model_reset();
    set_inputs(1'b0);
    enable = 1'b1;
    p_len = pl;
    c_len = cl;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst_n) model_step(enable, prod_done, cons_done);
    cyc++;
    #1;
  endtask

  task automatic drive();
    prod_done = (p_len > 0) && (m_p_age == p_len);
    cons_done = (c_len > 0) && (m_c_age == c_len);
    p_addr_a = AW'($urandom_range(511, 0)); p_addr_b = AW'($urandom_range(511, 0));
    c_addr_a = AW'($urandom_range(511, 0)); c_addr_b = AW'($urandom_range(511, 0));
    {p_rden_a, p_rden_b, p_wren_a, p_wren_b} = 4'($urandom_range(15, 0));
    {c_rden_a, c_rden_b, c_wren_a, c_wren_b} = 4'($urandom_range(15, 0));
  endtask

  initial begin
    model_reset();
    set_inputs(1'b1);
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod_en",  32'(o_prod_enable), 32'd0);
    chk("rst_prod_rst", 32'(o_prod_reset),  32'd0);
    chk("rst_cons_en",  32'(o_cons_enable), 32'd0);
    chk("rst_frames",   32'(o_frames_done), 32'd0);
    chk("rst_b0",       32'({o_b0_addr_a, o_b0_rden_a, o_b0_wren_a, o_b0_wren_b}), 32'd0);
    chk("rst_b1",       32'({o_b1_addr_b, o_b1_rden_b, o_b1_wren_a, o_b1_wren_b}), 32'd0);

    // Basic handoff: producer 20 cycles, consumer 30 cycles.
    start_scn(20, 30);
    for (int i = 0; i < 40; i++) begin
      edge_step();
      if (cyc == 1)  chk("A_prod_reset_c1", 32'(o_prod_reset), 32'd1);
      if (cyc == 2)  chk("A_prod_enable_c2", 32'({o_prod_enable, o_prod_reset}), 32'b10);
      if (cyc == 22) chk("A_prod_enable_fall", 32'(o_prod_enable), 32'd0);
      if (cyc == 23) chk("A_both_reset", 32'({o_cons_reset, o_prod_reset, o_cons_q_sel}), 32'b110);
      if (cyc == 24) chk("A_cons_enable", 32'(o_cons_enable), 32'd1);
      drive();
      if (cyc == 5) begin
        p_wren_a = 1'b1;
        p_addr_a = 9'h1A5;
        #1;
        chk("A_b0_follows_prod", 32'({o_b0_wren_a, o_b0_addr_a, o_b1_wren_a}), 32'({1'b1, 9'h1A5, 1'b0}));
      end
    end

    // Slow consumer stalls the producer; stray prod_done while idle is ignored.
    start_scn(10, 100);
    for (int i = 0; i < 120; i++) begin
      edge_step();
      if (cyc == 24)  chk("B_prod_done2", 32'(o_prod_enable), 32'd0);
      if (cyc == 60)  chk("B_stall", 32'({o_prod_enable, o_prod_reset, o_cons_enable}), 32'b001);
      if (cyc == 114) chk("B_cons_done", 32'({o_cons_enable, o_prod_reset, o_frames_done}), 32'd1);
      if (cyc == 115) chk("B_restart", 32'({o_prod_reset, o_cons_reset, o_cons_q_sel}), 32'b111);
      drive();
      if (cyc == 30) prod_done = 1'b1;
    end

    // Simultaneous prod_done and cons_done.
    start_scn(10, 10);
    for (int i = 0; i < 30; i++) begin
      edge_step();
      if (cyc == 24) chk("C_same_cycle", 32'({o_frames_done, o_cons_q_sel, o_prod_enable, o_cons_enable}),
                         32'({8'd1, 1'b1, 1'b0, 1'b0}));
      if (cyc == 25) chk("C_both_restart", 32'({o_prod_reset, o_cons_reset}), 32'b11);
      drive();
    end

    // enable falls while the producer runs: it finishes, nothing new starts.
    start_scn(10, 10);
    for (int i = 0; i < 25; i++) begin
      edge_step();
      if (cyc == 11) chk("E_run_continues", 32'(o_prod_enable), 32'd1);
      if (cyc == 12) chk("E_run_ends", 32'(o_prod_enable), 32'd0);
      if (cyc == 20) chk("E_no_start", 32'({o_prod_reset, o_cons_reset, o_cons_enable}), 32'd0);
      drive();
      if (cyc == 5) enable = 1'b0;
    end

    // Producer never finishes.
    start_scn(0, 0);
    for (int i = 0; i < 60; i++) begin
      edge_step();
`ifdef PINGPONG_WDOG_EN
      if (cyc == 51) chk("W_before_limit", 32'({o_prod_enable, o_wdog_err}), 32'b10);
      if (cyc == 52) chk("W_timeout", 32'({o_prod_enable, o_wdog_err}), 32'b01);
`else
      if (cyc == 52) chk("W_no_wdog", 32'({o_prod_enable, o_wdog_err}), 32'b10);
`endif
      drive();
`ifdef PINGPONG_WDOG_EN
      if (cyc == 52) begin
        p_wren_a = 1'b1;
        #1;
        chk("W_bank_freed", 32'(o_b0_wren_a), 32'd0);
      end
`endif
    end

    // 256 frames wrap the counter, then an asynchronous reset mid-run.
    start_scn(2, 2);
    for (int i = 0; i < 1030; i++) begin
      edge_step();
      if (cyc == 1027) chk("D_frames_255", 32'(o_frames_done), 32'd255);
      if (cyc == 1028) chk("D_frames_wrap", 32'(o_frames_done), 32'd0);
      if (cyc == 1030) chk("D_in_run", 32'(o_prod_enable), 32'd1);
      drive();
      if (cyc == 1030) begin
        p_wren_a = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("D_async_rst", 32'({o_prod_enable, o_prod_reset, o_cons_enable, o_cons_reset, o_cons_q_sel}), 32'd0);
        chk("D_async_rst_b", 32'({o_b0_wren_a, o_b1_wren_a, o_frames_done}), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    chk("D_hold_rst", 32'({o_prod_enable, o_frames_done}), 32'd0);
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
